// File: rtl/jtag_pkg.sv
// TAP state encoding, instruction opcodes and the 1149.1 next-state table.
// Latency: none (definitions and a pure function only).
// Backpressure: none; users advance the table only on detected tck rising edges.
package jtag_pkg;

    // Standard 1149.1 state encoding, so tap_state matches common debugger views.
    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PAU_DR = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PAU_IR = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_e;

    // Opcodes; cast to IR width at the point of use. -1 truncates to all-ones.
    localparam int OP_IDCODE = 1;
    localparam int OP_USER   = 2;
    localparam int OP_BYPASS = -1;

    // TAP transition taken on a tck rising edge for the sampled tms.
    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        tap_state_e n;
        n = TLR;
        case (s)
            TLR:     n = tms ? TLR    : RTI;
            RTI:     n = tms ? SEL_DR : RTI;
            SEL_DR:  n = tms ? SEL_IR : CAP_DR;
            CAP_DR:  n = tms ? EX1_DR : SH_DR;
            SH_DR:   n = tms ? EX1_DR : SH_DR;
            EX1_DR:  n = tms ? UPD_DR : PAU_DR;
            PAU_DR:  n = tms ? EX2_DR : PAU_DR;
            EX2_DR:  n = tms ? UPD_DR : SH_DR;
            UPD_DR:  n = tms ? SEL_DR : RTI;
            SEL_IR:  n = tms ? TLR    : CAP_IR;
            CAP_IR:  n = tms ? EX1_IR : SH_IR;
            SH_IR:   n = tms ? EX1_IR : SH_IR;
            EX1_IR:  n = tms ? UPD_IR : PAU_IR;
            PAU_IR:  n = tms ? EX2_IR : PAU_IR;
            EX2_IR:  n = tms ? UPD_IR : SH_IR;
            UPD_IR:  n = tms ? SEL_DR : RTI;
            default: n = TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// Pin synchroniser, tck edge detector and 16-state TAP FSM in the clk domain.
// Latency: tck pin edge -> tck_r/tck_f strobe SYNC_STG+1 clk; state moves on the strobe clk.
// Backpressure: none; every sampled tck edge is acted on, clk must be >= 4x tck.
module jtag_tap_fsm
    import jtag_pkg::*;
#(
    parameter int SYNC_STG = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tck,
    input  logic       tms,
    input  logic       tdi,
    output logic       tck_r,
    output logic       tck_f,
    output logic       tdi_s,
    output logic [3:0] tap_state
);

    logic [SYNC_STG-1:0] tck_sync_q;
    logic [SYNC_STG-1:0] tms_sync_q;
    logic [SYNC_STG-1:0] tdi_sync_q;
    logic                tck_d_q;
    logic                tck_r_q;
    logic                tck_f_q;
    logic                tms_q;
    logic                tdi_q;
    tap_state_e          state_q;
    tap_state_e          state_d;

    // Equal-depth synchronisers plus one register stage, so tms/tdi line up with the edge strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_sync_q <= '0;
            tms_sync_q <= '0;
            tdi_sync_q <= '0;
            tck_d_q    <= 1'b0;
            tck_r_q    <= 1'b0;
            tck_f_q    <= 1'b0;
            tms_q      <= 1'b0;
            tdi_q      <= 1'b0;
        end else begin
            tck_sync_q <= {tck_sync_q[SYNC_STG-2:0], tck};
            tms_sync_q <= {tms_sync_q[SYNC_STG-2:0], tms};
            tdi_sync_q <= {tdi_sync_q[SYNC_STG-2:0], tdi};
            tck_d_q    <= tck_sync_q[SYNC_STG-1];
            tck_r_q    <= tck_sync_q[SYNC_STG-1] & ~tck_d_q;
            tck_f_q    <= ~tck_sync_q[SYNC_STG-1] & tck_d_q;
            tms_q      <= tms_sync_q[SYNC_STG-1];
            tdi_q      <= tdi_sync_q[SYNC_STG-1];
        end
    end

    // TAP state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: only a tck rising strobe advances the TAP.
    always_comb begin
        state_d = state_q;
        if (tck_r_q) begin
            state_d = tap_next(state_q, tms_q);
        end
    end

    assign tck_r     = tck_r_q;
    assign tck_f     = tck_f_q;
    assign tdi_s     = tdi_q;
    assign tap_state = state_q;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller with IR, BYPASS, USER and optional IDCODE (JTAG_IDCODE_EN) registers.
// Latency: tdo/tdo_oe settle SYNC_STG+2 clk after tck falls; user_upd SYNC_STG+2 clk after Update-DR tck rise.
// Backpressure: none; the JTAG host paces everything and user_upd is a single-clk pulse the fabric must take.
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int          DEFAULT  = 32,
    parameter int          IR_W     = 4,
    parameter logic [31:0] IDCODE   = 32'h1000_0001,
    parameter int          SYNC_STG = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tck,
    input  logic               tms,
    input  logic               tdi,
    output logic               tdo,
    output logic               tdo_oe,
    output logic [3:0]         tap_state,
    output logic [IR_W-1:0]    ir_out,
    input  logic [DEFAULT-1:0] user_cap,
    output logic [DEFAULT-1:0] user_dr,
    output logic               user_upd
);

    localparam logic [IR_W-1:0] OP_BYP_W   = IR_W'(OP_BYPASS);
    localparam logic [IR_W-1:0] OP_USR_W   = IR_W'(OP_USER);
    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(2'b01);
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_W-1:0] OP_IDC_W   = IR_W'(OP_IDCODE);
    localparam logic [IR_W-1:0] IR_RESET   = OP_IDC_W;
`else
    localparam logic [IR_W-1:0] IR_RESET   = OP_BYP_W;
    // IDCODE is only consumed when the IDCODE register is built.
    localparam logic unused_idcode_lsb = IDCODE[0];
`endif

    logic               tck_r;
    logic               tck_f;
    logic               tdi_s;
    logic [IR_W-1:0]    ir_q, ir_d;
    logic [IR_W-1:0]    shift_ir_q, shift_ir_d;
    logic [DEFAULT-1:0] shift_usr_q, shift_usr_d;
    logic [DEFAULT-1:0] user_dr_q, user_dr_d;
    logic               byp_q, byp_d;
    logic               tdo_q, tdo_d;
    logic               tdo_oe_q, tdo_oe_d;
    logic               user_upd_q, user_upd_d;
    logic               sel_usr;
    logic               sel_idc;
    logic               dr_lsb;
`ifdef JTAG_IDCODE_EN
    logic [31:0]        shift_idc_q, shift_idc_d;
`endif

    jtag_tap_fsm #(
        .SYNC_STG (SYNC_STG)
    ) u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tck_r     (tck_r),
        .tck_f     (tck_f),
        .tdi_s     (tdi_s),
        .tap_state (tap_state)
    );

    // Instruction decode; anything unrecognised falls through to the 1-bit BYPASS register.
    assign sel_usr = (ir_q == OP_USR_W);
`ifdef JTAG_IDCODE_EN
    assign sel_idc = (ir_q == OP_IDC_W);
    assign dr_lsb  = sel_usr ? shift_usr_q[0] : (sel_idc ? shift_idc_q[0] : byp_q);
`else
    assign sel_idc = 1'b0;
    assign dr_lsb  = sel_usr ? shift_usr_q[0] : byp_q;
`endif

    // IR/DR capture, shift and update on tck rise; tdo and its enable on tck fall.
    always_comb begin
        ir_d        = ir_q;
        shift_ir_d  = shift_ir_q;
        shift_usr_d = shift_usr_q;
        user_dr_d   = user_dr_q;
        byp_d       = byp_q;
        tdo_d       = tdo_q;
        tdo_oe_d    = tdo_oe_q;
        user_upd_d  = 1'b0;
`ifdef JTAG_IDCODE_EN
        shift_idc_d = shift_idc_q;
`endif
        if (tap_state == TLR) begin
            ir_d = IR_RESET;
        end
        if (tck_r) begin
            case (tap_state)
                CAP_IR: shift_ir_d = IR_CAPTURE;
                SH_IR: begin
                    shift_ir_d         = shift_ir_q >> 1;
                    shift_ir_d[IR_W-1] = tdi_s;
                end
                UPD_IR: ir_d = shift_ir_q;
                CAP_DR: begin
                    if (sel_usr) begin
                        shift_usr_d = user_cap;
                    end else if (sel_idc) begin
`ifdef JTAG_IDCODE_EN
                        shift_idc_d = IDCODE;
`endif
                    end else begin
                        byp_d = 1'b0;
                    end
                end
                SH_DR: begin
                    if (sel_usr) begin
                        shift_usr_d            = shift_usr_q >> 1;
                        shift_usr_d[DEFAULT-1] = tdi_s;
                    end else if (sel_idc) begin
`ifdef JTAG_IDCODE_EN
                        shift_idc_d     = shift_idc_q >> 1;
                        shift_idc_d[31] = tdi_s;
`endif
                    end else begin
                        byp_d = tdi_s;
                    end
                end
                UPD_DR: begin
                    if (sel_usr) begin
                        user_dr_d  = shift_usr_q;
                        user_upd_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (tck_f) begin
            tdo_oe_d = (tap_state == SH_DR) || (tap_state == SH_IR);
            if (tap_state == SH_IR) begin
                tdo_d = shift_ir_q[0];
            end else if (tap_state == SH_DR) begin
                tdo_d = dr_lsb;
            end
        end
    end

    // Register file for the datapath; reset drops any partial shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q        <= IR_RESET;
            shift_ir_q  <= '0;
            shift_usr_q <= '0;
            user_dr_q   <= '0;
            byp_q       <= 1'b0;
            tdo_q       <= 1'b0;
            tdo_oe_q    <= 1'b0;
            user_upd_q  <= 1'b0;
        end else begin
            ir_q        <= ir_d;
            shift_ir_q  <= shift_ir_d;
            shift_usr_q <= shift_usr_d;
            user_dr_q   <= user_dr_d;
            byp_q       <= byp_d;
            tdo_q       <= tdo_d;
            tdo_oe_q    <= tdo_oe_d;
            user_upd_q  <= user_upd_d;
        end
    end

`ifdef JTAG_IDCODE_EN
    // IDCODE shift register, present only in IDCODE-enabled builds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_idc_q <= '0;
        end else begin
            shift_idc_q <= shift_idc_d;
        end
    end
`endif

    assign ir_out   = ir_q;
    assign tdo      = tdo_q;
    assign tdo_oe   = tdo_oe_q;
    assign user_dr  = user_dr_q;
    assign user_upd = user_upd_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Scoreboard bench for jtag_tap_ctrl: stimulus queues expected tdo bits, a monitor pops them.
// tck runs at 1/16 of clk; tdo is sampled 60 time units after each tck fall.
// Register-level results (state, IR, USER DR, update pulse) are checked inline by the stimulus.
module tb_jtag_tap_ctrl;

`ifdef JTAG_IDCODE_EN
    localparam logic [3:0]  IR_RST = 4'h1;
    localparam logic [31:0] T2_EXP = 32'h1000_0001;
    localparam logic [31:0] OP1_EXP = 32'h0000_0001;
`else
    localparam logic [3:0]  IR_RST = 4'hF;
    localparam logic [31:0] T2_EXP = 32'h0000_0000;
    localparam logic [31:0] OP1_EXP = 32'h0000_0078;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        tck   = 1'b0;
    logic        tms   = 1'b1;
    logic        tdi   = 1'b0;
    logic        tdo;
    logic        tdo_oe;
    logic [3:0]  tap_state;
    logic [3:0]  ir_out;
    logic [31:0] user_cap = 32'h0;
    logic [31:0] user_dr;
    logic        user_upd;

    int   errors  = 0;
    int   checks  = 0;
    int   upd_cnt = 0;
    int   upd_base;
    int   bit_idx = 0;
    logic mon_e;
    logic exp_q[$];

    jtag_tap_ctrl #(
        .DEFAULT  (32),
        .IR_W     (4),
        .IDCODE   (32'h1000_0001),
        .SYNC_STG (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .tdo_oe    (tdo_oe),
        .tap_state (tap_state),
        .ir_out    (ir_out),
        .user_cap  (user_cap),
        .user_dr   (user_dr),
        .user_upd  (user_upd)
    );

    always #5 clk = ~clk;

    // Clocks spent with user_upd high.
    always @(negedge clk) begin
        if (user_upd === 1'b1) upd_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tck_cycle(input logic m, input logic d);
        tms = m;
        tdi = d;
        #40 tck = 1'b1;
        #80 tck = 1'b0;
        #40;
    endtask

    task automatic goto_tlr();
        repeat (5) tck_cycle(1'b1, 1'b0);
    endtask

    // From TLR/RTI: scan n DR bits, expecting exp LSB-first on tdo; ends in RTI.
    task automatic shift_dr(input logic [31:0] din, input int n, input logic [31:0] exp);
        exp_q.push_back(exp[0]);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (i < n - 1) exp_q.push_back(exp[i+1]);
            tck_cycle(i == n - 1, din[i]);
        end
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
    endtask

    // From TLR/RTI: load a 4-bit IR; the captured 4'b0001 comes out on tdo; ends in RTI.
    task automatic shift_ir(input logic [3:0] din);
        exp_q.push_back(1'b1);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) exp_q.push_back(1'b0);
            tck_cycle(i == 3, din[i]);
        end
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
    endtask

    // Monitor: every tck fall with tdo_oe high must match the next queued bit.
    initial begin : monitor
        forever begin
            @(negedge tck);
            #60;
            if (tdo_oe === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tdo_extra: tdo=%b driven with no expected bit", tdo);
                end else begin
                    mon_e = exp_q.pop_front();
                    check($sformatf("tdo_bit%0d", bit_idx), {31'b0, tdo}, {31'b0, mon_e});
                    bit_idx++;
                end
            end
        end
    end

    initial begin : stim
        #22;
        check("rst_state",    {28'b0, tap_state}, 32'hF);
        check("rst_ir",       {28'b0, ir_out}, {28'b0, IR_RST});
        check("rst_tdo",      {31'b0, tdo}, 32'h0);
        check("rst_tdo_oe",   {31'b0, tdo_oe}, 32'h0);
        check("rst_user_dr",  user_dr, 32'h0);
        check("rst_user_upd", {31'b0, user_upd}, 32'h0);
        rst_n = 1'b1;
        #10;

        // 1: basic navigation and the five-ones return to Test-Logic-Reset.
        tck_cycle(1'b0, 1'b0);
        check("t1_rti", {28'b0, tap_state}, 32'hC);
        tck_cycle(1'b1, 1'b0);
        check("t1_sel_dr", {28'b0, tap_state}, 32'h7);
        goto_tlr();
        check("t1_tlr", {28'b0, tap_state}, 32'hF);
        check("t1_ir", {28'b0, ir_out}, {28'b0, IR_RST});
        check("t1_tdo_oe", {31'b0, tdo_oe}, 32'h0);

        // 2: reset instruction's DR.
        shift_dr(32'h0, 32, T2_EXP);
        check("t2_rti", {28'b0, tap_state}, 32'hC);

        // 3: USER capture and update.
        shift_ir(4'h2);
        check("t3_ir", {28'b0, ir_out}, 32'h2);
        user_cap = 32'hDEAD_BEEF;
        upd_base = upd_cnt;
        shift_dr(32'h1234_5678, 32, 32'hDEAD_BEEF);
        check("t3_user_dr", user_dr, 32'h1234_5678);
        check("t3_upd_clks", upd_cnt - upd_base, 32'd1);

        // 4: undefined opcode behaves as BYPASS: 0 then tdi delayed one tck (A5 -> 4A).
        shift_ir(4'h7);
        check("t4_ir", {28'b0, ir_out}, 32'h7);
        upd_base = upd_cnt;
        shift_dr(32'h0000_00A5, 8, 32'h0000_004A);
        check("t4_user_dr_held", user_dr, 32'h1234_5678);
        check("t4_upd_clks", upd_cnt - upd_base, 32'd0);

        // Opcode 1: IDCODE when built, BYPASS otherwise (3C -> 78).
        shift_ir(4'h1);
        check("op1_ir", {28'b0, ir_out}, 32'h1);
        shift_dr(32'h0000_003C, 8, OP1_EXP);

        // 5: Shift-IR, pause 10 tck, resume without re-capture; IR ends at 4'h2.
        exp_q.push_back(1'b1);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        exp_q.push_back(1'b0);
        tck_cycle(1'b0, 1'b1);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        repeat (10) tck_cycle(1'b0, 1'b0);
        check("t5_pause", {28'b0, tap_state}, 32'hB);
        tck_cycle(1'b1, 1'b0);
        exp_q.push_back(1'b0);
        tck_cycle(1'b0, 1'b0);
        exp_q.push_back(1'b0);
        tck_cycle(1'b0, 1'b1);
        exp_q.push_back(1'b1);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        check("t5_ir", {28'b0, ir_out}, 32'h2);

        // 6: reset in the middle of a USER Shift-DR.
        user_cap = 32'hCAFE_F00D;
        upd_base = upd_cnt;
        exp_q.push_back(user_cap[0]);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(user_cap[i+1]);
            tck_cycle(1'b0, 1'b1);
        end
        #30;
        check("t6_pre_tdo_oe", {31'b0, tdo_oe}, 32'h1);
        rst_n = 1'b0;
        #10;
        check("t6_state",    {28'b0, tap_state}, 32'hF);
        check("t6_ir",       {28'b0, ir_out}, {28'b0, IR_RST});
        check("t6_tdo",      {31'b0, tdo}, 32'h0);
        check("t6_tdo_oe",   {31'b0, tdo_oe}, 32'h0);
        check("t6_user_dr",  user_dr, 32'h0);
        #20;
        rst_n = 1'b1;
        #200;
        check("t6_state_after", {28'b0, tap_state}, 32'hF);
        check("t6_upd_clks", upd_cnt - upd_base, 32'd0);
        check("tdo_queue_left", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
